ddr3_iod_dly_step_ctrl: RTL and testbench

//  Fabric-side sequencer for the dynamic delay lines of a group of NUM_LANES PolarFire IOD output lanes (CKE/CS/ODT/CA).

---
 rtl/ddr3_iod_dly_step_ctrl_if.sv | 26 ++
 rtl/ddr3_iod_dly_step_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ddr3_iod_dly_step_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_iod_dly_step_ctrl_if.sv
// Request/completion bus between DDR PHY training logic and the IOD delay-step sequencer.
interface ddr3_iod_dly_step_ctrl_if #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [LANE_W-1:0] req_lane;
    logic [1:0]        req_op;
    logic [TAP_W-1:0]  req_tap;
    logic              done;
    logic              done_err;
    logic [TAP_W-1:0]  done_tap;

    modport master (
        output req_valid, req_lane, req_op, req_tap,
        input  req_ready, done, done_err, done_tap
    );

    modport slave (
        input  req_valid, req_lane, req_op, req_tap,
        output req_ready, done, done_err, done_tap
    );
endinterface

// File: rtl/ddr3_iod_dly_step_ctrl.sv
// Sequences LOAD/MOVE/DIRECTION pulses for one selected IOD delay lane per request
// and tracks the current tap of every lane.
module ddr3_iod_dly_step_ctrl #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8,
    parameter int MOVE_GAP  = 3,
    parameter int LOAD_TAP  = 1
) (
    input  logic                       fab_clk,
    input  logic                       arst_n,
    ddr3_iod_dly_step_ctrl_if.slave    req,
    output logic [NUM_LANES*TAP_W-1:0] tap_cur,
    output logic [NUM_LANES-1:0]       delay_line_load,
    output logic [NUM_LANES-1:0]       delay_line_move,
    output logic [NUM_LANES-1:0]       delay_line_direction,
    input  logic [NUM_LANES-1:0]       delay_line_out_of_range
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int GAP_W  = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       state_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [1:0]       op_reg;
    logic [TAP_W-1:0] step_reg;
    logic [TAP_W-1:0] target_reg;
    logic             dir_reg;
    logic             err_reg;
    logic [GAP_W-1:0] gap_cnt_reg;

    logic              lane_ok;
    logic              req_lane_ok;
    logic [LANE_W-1:0] lane_sel;
    logic [TAP_W-1:0]  cur;
    logic [TAP_W:0]    sum;
    logic [TAP_W-1:0]  target_calc;
    logic              dir_calc;
    logic              dir_now;
    logic              dir_phase;
    logic              oor_hit;
    logic              tap_wr_en;
    logic [TAP_W-1:0]  tap_wr_val;

    assign lane_ok     = 32'(lane_reg) < NUM_LANES;
    assign req_lane_ok = 32'(req.req_lane) < NUM_LANES;
    assign lane_sel    = lane_ok ? lane_reg : '0;
    assign cur         = tap_cur[lane_sel*TAP_W +: TAP_W];

    // Sum carries into the extra bit, so INC saturates instead of wrapping.
    always_comb begin
        sum         = {1'b0, cur} + {1'b0, step_reg};
        target_calc = cur;
        case (op_reg)
            OP_SET:  target_calc = step_reg;
            OP_INC:  target_calc = sum[TAP_W] ? {TAP_W{1'b1}} : sum[TAP_W-1:0];
            OP_DEC:  target_calc = (step_reg > cur) ? '0 : cur - step_reg;
            default: target_calc = cur;
        endcase
    end

    assign dir_calc  = target_calc > cur;
    assign dir_now   = (state_reg == S_CALC) ? dir_calc : dir_reg;
    assign dir_phase = lane_ok && (op_reg != OP_LOAD) &&
                       ((state_reg == S_CALC) || (state_reg == S_STEP) ||
                        (state_reg == S_GAP)  || (state_reg == S_DONE));
    assign oor_hit   = (state_reg == S_GAP) && (op_reg != OP_LOAD) &&
                       delay_line_out_of_range[lane_sel];

    // An out-of-range abort backs out the step that caused it.
    always_comb begin
        tap_wr_en  = 1'b0;
        tap_wr_val = cur;
        case (state_reg)
            S_LOAD: begin
                tap_wr_en  = 1'b1;
                tap_wr_val = TAP_W'(LOAD_TAP);
            end
            S_STEP: begin
                tap_wr_en  = 1'b1;
                tap_wr_val = dir_reg ? cur + TAP_W'(1) : cur - TAP_W'(1);
            end
            S_GAP: begin
                tap_wr_en  = oor_hit;
                tap_wr_val = dir_reg ? cur - TAP_W'(1) : cur + TAP_W'(1);
            end
            default: begin
                tap_wr_en  = 1'b0;
                tap_wr_val = cur;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : lane_g
            logic             lane_hit;
            logic [TAP_W-1:0] tap_reg;

            assign lane_hit = lane_ok && (lane_reg == LANE_W'(gi));

            always_ff @(posedge fab_clk or negedge arst_n) begin
                if (!arst_n)
                    tap_reg <= TAP_W'(LOAD_TAP);
                else if (tap_wr_en && lane_hit)
                    tap_reg <= tap_wr_val;
            end

            assign tap_cur[gi*TAP_W +: TAP_W] = tap_reg;
            assign delay_line_load[gi]        = lane_hit && (state_reg == S_LOAD);
            assign delay_line_move[gi]        = lane_hit && (state_reg == S_STEP);
            assign delay_line_direction[gi]   = lane_hit && dir_phase && dir_now;
        end
    endgenerate

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg   <= S_IDLE;
            lane_reg    <= '0;
            op_reg      <= OP_LOAD;
            step_reg    <= '0;
            target_reg  <= '0;
            dir_reg     <= 1'b0;
            err_reg     <= 1'b0;
            gap_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req.req_valid) begin
                        lane_reg  <= req.req_lane;
                        op_reg    <= req.req_op;
                        step_reg  <= req.req_tap;
                        err_reg   <= 1'b0;
                        state_reg <= (req.req_op == OP_LOAD && req_lane_ok) ? S_LOAD : S_CALC;
                    end
                end
                S_CALC: begin
                    if (!lane_ok) begin
                        err_reg   <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        target_reg <= target_calc;
                        dir_reg    <= dir_calc;
                        state_reg  <= (target_calc == cur) ? S_DONE : S_STEP;
                    end
                end
                S_LOAD, S_STEP: begin
                    gap_cnt_reg <= GAP_W'(MOVE_GAP - 1);
                    state_reg   <= S_GAP;
                end
                S_GAP: begin
                    if (oor_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (gap_cnt_reg == '0) begin
                        state_reg <= (op_reg == OP_LOAD || cur == target_reg) ? S_DONE : S_STEP;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req.req_ready = (state_reg == S_IDLE);
    assign req.done      = (state_reg == S_DONE);
    assign req.done_err  = (state_reg == S_DONE) && err_reg;
    assign req.done_tap  = (state_reg == S_DONE && lane_ok) ? cur : '0;
endmodule

// File: tb/tb_ddr3_iod_dly_step_ctrl.sv
// Bench for ddr3_iod_dly_step_ctrl: six lanes so that lane indices 6/7 exercise the bad-lane path.
module tb_ddr3_iod_dly_step_ctrl;
    localparam int NL = 6;
    localparam int TW = 8;
    localparam int G  = 3;
    localparam int LT = 1;
    localparam int LW = 3;
    localparam int TMAX = 255;

    logic fab_clk = 1'b0;
    logic arst_n  = 1'b0;
    always #5 fab_clk = ~fab_clk;

    ddr3_iod_dly_step_ctrl_if #(.NUM_LANES(NL), .TAP_W(TW)) bus ();

    logic [NL*TW-1:0] tap_cur;
    logic [NL-1:0]    dl_load;
    logic [NL-1:0]    dl_move;
    logic [NL-1:0]    dl_dir;
    logic [NL-1:0]    dl_oor;

    ddr3_iod_dly_step_ctrl #(
        .NUM_LANES(NL), .TAP_W(TW), .MOVE_GAP(G), .LOAD_TAP(LT)
    ) dut (
        .fab_clk                 (fab_clk),
        .arst_n                  (arst_n),
        .req                     (bus.slave),
        .tap_cur                 (tap_cur),
        .delay_line_load         (dl_load),
        .delay_line_move         (dl_move),
        .delay_line_direction    (dl_dir),
        .delay_line_out_of_range (dl_oor)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int model_tap [NL];

    logic          last_err;
    logic [TW-1:0] last_done_tap;

    // Drives one request and checks every cycle against timing derived from the tap rules:
    // N = |target-cur| moves at 2+k*(G+1), DONE at 2+N*(G+1); an out-of-range pulse on the
    // selected lane in a gap cycle c ends the operation at c+1 with the last move undone.
    task automatic run_op(input int lane, input int op, input int tap,
                          input int oor_lane, input int oor_cyc, input bit hold);
        int cur, target, n, m, done_cyc, fin, period;
        bit ok, isload, dir, abort;
        logic [NL-1:0] oh, exp_move, exp_load, exp_dir;
        period = G + 1;
        ok     = (lane < NL);
        isload = ok && (op == 0);
        oh     = ok ? (NL'(1) << lane) : '0;
        cur    = ok ? model_tap[lane] : 0;
        abort  = 0;
        dir    = 0;
        m      = 0;
        target = cur;
        if (!ok) begin
            done_cyc = 2;
            fin      = 0;
        end else if (isload) begin
            done_cyc = 2 + G;
            fin      = LT;
        end else begin
            if (op == 1) target = tap;
            else if (op == 2) target = (cur + tap > TMAX) ? TMAX : cur + tap;
            else target = (cur - tap < 0) ? 0 : cur - tap;
            n        = (target > cur) ? target - cur : cur - target;
            dir      = (target > cur);
            m        = n;
            done_cyc = 2 + n * period;
            fin      = target;
            if (oor_lane == lane && oor_cyc > 2 && oor_cyc < done_cyc &&
                ((oor_cyc - 2) % period) != 0) begin
                abort    = 1;
                m        = (oor_cyc - 2) / period + 1;
                done_cyc = oor_cyc + 1;
                fin      = dir ? cur + m - 1 : cur - (m - 1);
            end
        end

        @(negedge fab_clk);
        bus.req_valid = 1'b1;
        bus.req_lane  = LW'(lane);
        bus.req_op    = 2'(op);
        bus.req_tap   = TW'(tap);
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_idle: got %b want 1", bus.req_ready);
        end
        @(posedge fab_clk);
        #1;
        if (hold) begin
            bus.req_lane = LW'($urandom_range(0, NL - 1));
            bus.req_op   = 2'($urandom_range(0, 3));
            bus.req_tap  = TW'($urandom_range(0, 255));
        end else begin
            bus.req_valid = 1'b0;
        end

        for (int k = 1; k <= done_cyc; k++) begin
            @(negedge fab_clk);
            exp_move = (ok && !isload && k >= 2 && ((k - 2) % period) == 0 &&
                        ((k - 2) / period) < m) ? oh : '0;
            exp_load = (isload && k == 1) ? oh : '0;
            exp_dir  = (ok && !isload && dir) ? oh : '0;
            tests_run++;
            if (dl_move !== exp_move) begin
                tests_failed++;
                $display("FAIL move cyc%0d: got %b want %b", k, dl_move, exp_move);
            end
            tests_run++;
            if (dl_load !== exp_load) begin
                tests_failed++;
                $display("FAIL load cyc%0d: got %b want %b", k, dl_load, exp_load);
            end
            tests_run++;
            if (bus.done !== (k == done_cyc)) begin
                tests_failed++;
                $display("FAIL done cyc%0d: got %b want %b", k, bus.done, (k == done_cyc));
            end
            tests_run++;
            if (bus.req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL ready_busy cyc%0d: got %b want 0", k, bus.req_ready);
            end
            if (k < done_cyc) begin
                tests_run++;
                if (dl_dir !== exp_dir) begin
                    tests_failed++;
                    $display("FAIL direction cyc%0d: got %b want %b", k, dl_dir, exp_dir);
                end
            end else begin
                last_err      = bus.done_err;
                last_done_tap = bus.done_tap;
                bus.req_valid = 1'b0;
                tests_run++;
                if (bus.done_err !== (!ok || abort)) begin
                    tests_failed++;
                    $display("FAIL done_err: got %b want %b", bus.done_err, (!ok || abort));
                end
                tests_run++;
                if (bus.done_tap !== TW'(fin)) begin
                    tests_failed++;
                    $display("FAIL done_tap: got %0d want %0d", bus.done_tap, fin);
                end
            end
            if (k == oor_cyc && oor_lane >= 0 && oor_lane < NL)
                dl_oor = NL'(1) << oor_lane;
            else
                dl_oor = '0;
        end
        if (ok) model_tap[lane] = fin;

        @(negedge fab_clk);
        dl_oor = '0;
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_done: ready=%b done=%b want 1/0", bus.req_ready, bus.done);
        end
        for (int i = 0; i < NL; i++) begin
            tests_run++;
            if (tap_cur[i*TW +: TW] !== TW'(model_tap[i])) begin
                tests_failed++;
                $display("FAIL tap_cur[%0d]: got %0d want %0d", i, tap_cur[i*TW +: TW], model_tap[i]);
            end
        end
        $display("[TB] op=%0d lane=%0d tap=%0d oor=%0d@%0d -> done@%0d err=%0b done_tap=%0d",
                 op, lane, tap, oor_lane, oor_cyc, done_cyc, last_err, last_done_tap);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge fab_clk);
        arst_n = 1'b1;
        for (int i = 0; i < NL; i++) model_tap[i] = LT;
        @(negedge fab_clk);
        for (int i = 0; i < NL; i++) begin
            tests_run++;
            if (tap_cur[i*TW +: TW] !== TW'(LT)) begin
                tests_failed++;
                $display("FAIL reset_tap[%0d]: got %0d want %0d", i, tap_cur[i*TW +: TW], LT);
            end
        end
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.done !== 1'b0 || bus.done_err !== 1'b0 ||
            bus.done_tap !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: ready=%b done=%b err=%b tap=%0d want 1/0/0/0",
                     bus.req_ready, bus.done, bus.done_err, bus.done_tap);
        end
        tests_run++;
        if (dl_load !== '0 || dl_move !== '0 || dl_dir !== '0) begin
            tests_failed++;
            $display("FAIL reset_pins: load=%b move=%b dir=%b want 0", dl_load, dl_move, dl_dir);
        end
    endtask

    task automatic test_set();
        run_op(2, 1, 4, -1, -1, 0);
        tests_run++;
        if (last_done_tap !== 8'd4) begin
            tests_failed++;
            $display("FAIL set_done_tap: got %0d want 4", last_done_tap);
        end
    endtask

    task automatic test_dec_saturate();
        run_op(0, 3, 5, -1, -1, 0);
        tests_run++;
        if (tap_cur[0 +: TW] !== 8'd0 || last_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL dec_sat: tap=%0d err=%b want 0/0", tap_cur[0 +: TW], last_err);
        end
    endtask

    task automatic test_out_of_range();
        run_op(1, 2, 3, 1, 8, 0);
        tests_run++;
        if (last_err !== 1'b1 || last_done_tap !== 8'd2) begin
            tests_failed++;
            $display("FAIL oor_abort: err=%b tap=%0d want 1/2", last_err, last_done_tap);
        end
        run_op(1, 2, 3, 0, 8, 0);
        tests_run++;
        if (last_err !== 1'b0 || last_done_tap !== 8'd5) begin
            tests_failed++;
            $display("FAIL oor_other_lane: err=%b tap=%0d want 0/5", last_err, last_done_tap);
        end
    endtask

    task automatic test_load_and_bad_lane();
        run_op(3, 1, 9, -1, -1, 0);
        run_op(3, 0, 0, -1, -1, 0);
        tests_run++;
        if (tap_cur[3*TW +: TW] !== 8'd1) begin
            tests_failed++;
            $display("FAIL load_tap: got %0d want 1", tap_cur[3*TW +: TW]);
        end
        run_op(6, 2, 3, -1, -1, 0);
        run_op(7, 0, 0, -1, -1, 0);
    endtask

    task automatic test_inc_saturate();
        run_op(4, 1, 253, -1, -1, 0);
        run_op(4, 2, 9, -1, -1, 0);
        run_op(4, 2, 1, -1, -1, 0);
        tests_run++;
        if (tap_cur[4*TW +: TW] !== 8'd255) begin
            tests_failed++;
            $display("FAIL inc_sat: got %0d want 255", tap_cur[4*TW +: TW]);
        end
    endtask

    task automatic test_back_to_back();
        run_op(5, 1, 3, -1, -1, 1);
        run_op(5, 2, 2, -1, -1, 1);
        run_op(5, 3, 1, -1, -1, 0);
    endtask

    task automatic test_reset_mid_op();
        int cur2;
        cur2 = model_tap[2];
        @(negedge fab_clk);
        bus.req_valid = 1'b1;
        bus.req_lane  = LW'(2);
        bus.req_op    = 2'd1;
        bus.req_tap   = TW'(cur2 + 3);
        @(posedge fab_clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (7) @(negedge fab_clk);
        arst_n = 1'b0;
        #1;
        for (int i = 0; i < NL; i++) model_tap[i] = LT;
        tests_run++;
        if (dl_load !== '0 || dl_move !== '0 || dl_dir !== '0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_pins: load=%b move=%b dir=%b done=%b want 0",
                     dl_load, dl_move, dl_dir, bus.done);
        end
        for (int i = 0; i < NL; i++) begin
            tests_run++;
            if (tap_cur[i*TW +: TW] !== TW'(LT)) begin
                tests_failed++;
                $display("FAIL rst_mid_tap[%0d]: got %0d want %0d", i, tap_cur[i*TW +: TW], LT);
            end
        end
        repeat (2) begin
            @(negedge fab_clk);
            tests_run++;
            if (bus.done !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_done: got %b want 0", bus.done);
            end
        end
        arst_n = 1'b1;
        run_op(2, 1, 4, -1, -1, 0);
    endtask

    task automatic test_random();
        int lane, op, tap, ol, oc;
        for (int it = 0; it < 30; it++) begin
            lane = $urandom_range(0, 7);
            op   = $urandom_range(0, 3);
            tap  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            ol   = -1;
            oc   = -1;
            if (op != 0 && $urandom_range(0, 2) == 0) begin
                ol = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NL - 1) : lane;
                oc = 2 + $urandom_range(0, 3) * (G + 1) + $urandom_range(1, G);
            end
            run_op(lane, op, tap, ol, oc, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_lane  = '0;
        bus.req_op    = '0;
        bus.req_tap   = '0;
        dl_oor        = '0;
        test_reset();
        test_set();
        test_dec_saturate();
        test_out_of_range();
        test_load_and_bad_lane();
        test_inc_saturate();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
